// File: rtl/wb_reg_slave_if.sv
// WISHBONE classic bus bundle between a master and wb_reg_slave.
// Signal names keep the slave-side _i/_o suffixes so both ends read the same.
interface wb_reg_slave_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [20:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_reg_slave.sv
// WISHBONE register slave: ID, CTRL, STATUS, ACCESS_CNT and four SCRATCH words.
// Optional macro WBSLV_RTY_EN: busy back-end answers with rty_o instead of stalling.
module wb_reg_slave #(
  parameter logic [20:0] BASE_ADR    = 21'h000000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h57425347
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_reg_slave_if.slave  wb,
  input  logic           busy_i,
  input  logic [31:0]    stat_i,
  output logic [31:0]    ctrl_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic              hit_q, hit_d;
  logic              we_q, we_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       ctrl_q, ctrl_d;
  logic [31:0]       acc_q, acc_d;
  logic [3:0][31:0]  scr_q, scr_d;
  logic              ack_s, err_s, rty_s;
  logic [31:0]       rdat_s;
  logic              hit_s;
  logic              hold_s;
  logic              retry_s;

  function automatic logic [31:0] read_mux(input logic [2:0] idx, input logic [31:0] ctrl,
                                           input logic [31:0] stat, input logic [31:0] acc,
                                           input logic [3:0][31:0] scr);
    case (idx)
      3'd0:    return ID_VALUE;
      3'd1:    return ctrl;
      3'd2:    return stat;
      3'd3:    return acc;
      default: return scr[idx[1:0]];
    endcase
  endfunction

  assign hit_s = (wb.adr_i[20:3] == BASE_ADR[20:3]);

`ifdef WBSLV_RTY_EN
  assign hold_s  = 1'b0;
  assign retry_s = busy_i;
`else
  assign hold_s  = busy_i;
  assign retry_s = 1'b0;
`endif

  // Terminations are combinational so a dropped cyc_i or late busy_i can still veto them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    ctrl_d  = ctrl_q;
    acc_d   = acc_q;
    scr_d   = scr_q;
    ack_s   = 1'b0;
    err_s   = 1'b0;
    rty_s   = 1'b0;
    rdat_s  = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (wb.cyc_i && wb.stb_i) begin
          idx_d  = wb.adr_i[2:0];
          hit_d  = hit_s;
          we_d   = wb.we_i;
          wdat_d = wb.dat_i;
          cnt_d  = WS;
          if (WS == 4'd0 && !(hit_s && hold_s)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!wb.cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Counter parks at 0 while a busy back-end stalls a hit.
          cnt_d = 4'd0;
          if (hit_q && hold_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!wb.cyc_i) begin
          state_d = S_IDLE;
        end else if (!hit_q) begin
          err_s = 1'b1;
        end else if (retry_s) begin
          rty_s = 1'b1;
        end else begin
          ack_s = 1'b1;
          acc_d = acc_q + 32'd1;
          if (we_q) begin
            case (idx_q)
              3'd1:    ctrl_d = wdat_q;
              3'd3:    acc_d  = 32'h0000_0000;
              3'd4, 3'd5, 3'd6, 3'd7: scr_d[idx_q[1:0]] = wdat_q;
              default: ctrl_d = ctrl_q;
            endcase
          end else begin
            rdat_s = read_mux(idx_q, ctrl_q, stat_i, acc_q, scr_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register file update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      hit_q   <= 1'b0;
      we_q    <= 1'b0;
      wdat_q  <= 32'h0000_0000;
      ctrl_q  <= 32'h0000_0000;
      acc_q   <= 32'h0000_0000;
      scr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      ctrl_q  <= ctrl_d;
      acc_q   <= acc_d;
      scr_q   <= scr_d;
    end
  end

  assign wb.ack_o = ack_s;
  assign wb.err_o = err_s;
  assign wb.rty_o = rty_s;
  assign wb.dat_o = rdat_s;
  assign ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Scoreboard bench for wb_reg_slave (WAIT_STATES=1); expectations queued per request.
// Builds with or without WBSLV_RTY_EN.
module tb_wb_reg_slave;
  localparam logic [2:0] T_ACK = 3'b100;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b001;
  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [31:0] ID = 32'h57425347;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy = 1'b0;
  logic [31:0] stat = 32'h0;
  logic [31:0] ctrl;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [20:0] adr;
    logic [31:0] wd;
    logic [2:0]  term;
    logic [31:0] data;
    int          lat;
  } req_t;

  req_t exp_q[$];

  wb_reg_slave_if bus();

  wb_reg_slave #(.BASE_ADR(21'h000000), .WAIT_STATES(1), .ID_VALUE(32'h57425347)) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus.slave), .busy_i(busy), .stat_i(stat), .ctrl_o(ctrl)
  );

  always #5 clk = ~clk;

  // One request: drive at a falling edge, watch each later falling edge for a termination.
  task automatic xfer(input logic we, input logic [20:0] adr, input logic [31:0] wd,
                      output logic [2:0] term, output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = wd;
    term = T_NONE; rd = 32'h0; lat = 0;
    while (term == T_NONE && lat < 64) begin
      @(negedge clk);
      lat++;
      term = {bus.ack_o, bus.err_o, bus.rty_o};
      rd   = bus.dat_o;
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    @(negedge clk);
    checks++;
    if ({bus.ack_o, bus.err_o, bus.rty_o} !== T_NONE) begin
      errors++; $display("FAIL reset_term got=%b want=%b", {bus.ack_o, bus.err_o, bus.rty_o}, T_NONE);
    end
    checks++;
    if (bus.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h want=0", bus.dat_o); end
    checks++;
    if (ctrl !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", ctrl); end
  endtask

  // Runs every queued request and compares it, plus the idle cycle that follows.
  task automatic test_seq(input string name);
    req_t e;
    logic [2:0] term; logic [31:0] rd; int lat;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      xfer(e.we, e.adr, e.wd, term, rd, lat);
      checks++;
      if (term !== e.term || rd !== e.data || lat != e.lat) begin
        errors++;
        $display("FAIL %s adr=%h got term=%b data=%h lat=%0d want term=%b data=%h lat=%0d",
                 name, e.adr, term, rd, lat, e.term, e.data, e.lat);
      end
      @(negedge clk);
      checks++;
      if ({bus.ack_o, bus.err_o, bus.rty_o} !== T_NONE || bus.dat_o !== 32'h0) begin
        errors++;
        $display("FAIL %s_after got term=%b data=%h want term=000 data=0",
                 name, {bus.ack_o, bus.err_o, bus.rty_o}, bus.dat_o);
      end
    end
  endtask

  task automatic test_id_read();
    exp_q.push_back('{1'b0, 21'h0, 32'h0, T_ACK, ID, 2});
    test_seq("id_read");
  endtask

  task automatic test_ctrl_rw();
    logic [2:0] term; logic [31:0] rd; int lat;
    pulse_reset();
    xfer(1'b1, 21'h1, 32'hDEADBEEF, term, rd, lat);
    checks++;
    if (term !== T_ACK || lat != 2) begin
      errors++; $display("FAIL ctrl_write got term=%b lat=%0d want term=%b lat=2", term, lat, T_ACK);
    end
    checks++;
    if (ctrl !== 32'hDEADBEEF) begin errors++; $display("FAIL ctrl_o got=%h want=deadbeef", ctrl); end
    exp_q.push_back('{1'b0, 21'h1, 32'h0, T_ACK, 32'hDEADBEEF, 2});
    exp_q.push_back('{1'b0, 21'h3, 32'h0, T_ACK, 32'd2, 2});
    test_seq("ctrl_rw");
  endtask

  task automatic test_miss();
    exp_q.push_back('{1'b0, 21'h8, 32'h0, T_ERR, 32'h0, 2});
    exp_q.push_back('{1'b1, 21'h10, 32'h1111_2222, T_ERR, 32'h0, 2});
    exp_q.push_back('{1'b0, 21'h3, 32'h0, T_ACK, 32'd3, 2});
    test_seq("miss");
  endtask

  task automatic test_cnt_clear();
    exp_q.push_back('{1'b0, 21'h5, 32'h0, T_ACK, 32'h0, 2});
    exp_q.push_back('{1'b1, 21'h3, 32'h1234_0000, T_ACK, 32'h0, 2});
    exp_q.push_back('{1'b0, 21'h3, 32'h0, T_ACK, 32'd0, 2});
    exp_q.push_back('{1'b0, 21'h3, 32'h0, T_ACK, 32'd1, 2});
    test_seq("cnt_clear");
  endtask

  task automatic test_abort();
    logic [2:0] seen;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 21'h4; bus.dat_i = 32'hCAFE_0004;
      @(negedge clk);
      seen = {bus.ack_o, bus.err_o, bus.rty_o};
      if (k == 0) begin
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      end else begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      end
      repeat (4) begin
        @(negedge clk);
        seen = seen | {bus.ack_o, bus.err_o, bus.rty_o};
      end
      checks++;
      if (seen !== T_NONE) begin errors++; $display("FAIL abort%0d_term got=%b want=000", k, seen); end
    end
    checks++;
    if (ctrl !== 32'h0) begin errors++; $display("FAIL abort_ctrl got=%h want=0", ctrl); end
    exp_q.push_back('{1'b0, 21'h4, 32'h0, T_ACK, 32'h0, 2});
    exp_q.push_back('{1'b0, 21'h3, 32'h0, T_ACK, 32'd1, 2});
    test_seq("abort");
  endtask

  task automatic test_scratch();
    stat = 32'hA5A5_0F0F;
    for (int i = 4; i < 8; i++) begin
      exp_q.push_back('{1'b1, 21'(i), 32'h5C00_0000 + 32'(i), T_ACK, 32'h0, 2});
    end
    exp_q.push_back('{1'b1, 21'h0, 32'hFFFF_FFFF, T_ACK, 32'h0, 2});
    exp_q.push_back('{1'b1, 21'h2, 32'hFFFF_FFFF, T_ACK, 32'h0, 2});
    for (int i = 7; i >= 4; i--) begin
      exp_q.push_back('{1'b0, 21'(i), 32'h0, T_ACK, 32'h5C00_0000 + 32'(i), 2});
    end
    exp_q.push_back('{1'b0, 21'h0, 32'h0, T_ACK, ID, 2});
    exp_q.push_back('{1'b0, 21'h2, 32'h0, T_ACK, 32'hA5A5_0F0F, 2});
    test_seq("scratch");
  endtask

  task automatic test_busy();
    busy = 1'b1;
`ifdef WBSLV_RTY_EN
    exp_q.push_back('{1'b1, 21'h5, 32'h1234_5678, T_RTY, 32'h0, 2});
    test_seq("busy_rty");
    busy = 1'b0;
    exp_q.push_back('{1'b0, 21'h5, 32'h0, T_ACK, 32'h5C00_0005, 2});
    test_seq("busy_rty_rd");
`else
    fork
      begin
        repeat (6) @(negedge clk);
        busy = 1'b0;
      end
    join_none
    exp_q.push_back('{1'b1, 21'h5, 32'h1234_5678, T_ACK, 32'h0, 6});
    test_seq("busy_hold");
    exp_q.push_back('{1'b0, 21'h5, 32'h0, T_ACK, 32'h1234_5678, 2});
    test_seq("busy_hold_rd");
`endif
    busy = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{1'b0, 21'h0, 32'h0, T_ACK, ID, 2});
    exp_q.push_back('{1'b1, 21'h6, 32'h0BAD_F00D, T_ACK, 32'h0, 2});
    exp_q.push_back('{1'b0, 21'h6, 32'h0, T_ACK, 32'h0BAD_F00D, 2});
    exp_q.push_back('{1'b0, 21'h1FFFFF, 32'h0, T_ERR, 32'h0, 2});
    test_seq("back_to_back");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = 21'h0; bus.dat_i = 32'h0;
    test_reset();
    test_id_read();
    test_ctrl_rw();
    test_miss();
    test_cnt_clear();
    test_abort();
    test_scratch();
    test_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_reg_slave.md
WB_REG_SLAVE -- requirements
Module: wb_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADR, default 21'h000000, word address of the register window (bits [2:0] ignored).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15, added response delay in cycles.
REQ-003 SHALL have parameter ID_VALUE, default 32'h57425347, value returned by register 0.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cyc_i  input  1  WISHBONE cycle.
REQ-007 SHALL have port stb_i  input  1  WISHBONE strobe.
REQ-008 SHALL have port we_i  input  1  write enable.
REQ-009 SHALL have port adr_i  input  21  word address.
REQ-010 SHALL have port dat_i  input  32  write data.
REQ-011 SHALL have port dat_o  output  32  read data.
REQ-012 SHALL have port ack_o  output  1  normal termination.
REQ-013 SHALL have port err_o  output  1  error termination.
REQ-014 SHALL have port rty_o  output  1  retry termination.
REQ-015 SHALL have port busy_i  input  1  back-end busy.
REQ-016 SHALL have port stat_i  input  32  status word, read-only.
REQ-017 SHALL have port ctrl_o  output  32  contents of CTRL register.

Function
REQ-018 SHALL decode hit = (adr_i[20:3] == BASE_ADR[20:3]); index = adr_i[2:0].
REQ-019 SHALL map registers: 0 ID (RO), 1 CTRL (RW), 2 STATUS (RO, stat_i sampled in the response cycle), 3 ACCESS_CNT (RO; any write clears it), 4-7 SCRATCH (RW).
REQ-020 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-021 SHALL, in IDLE with cyc_i&stb_i high, latch adr_i, we_i and dat_i, load the wait counter with WAIT_STATES, and enter WAIT.
REQ-022 SHALL, in WAIT, decrement the counter and enter RESP when it reaches 0, so a request sampled in cycle N terminates in cycle N+1+WAIT_STATES.
REQ-023 SHALL assert exactly one of ack_o, err_o or rty_o for exactly one cycle in RESP, then return to IDLE; new requests are accepted from the following cycle.
REQ-024 SHALL drive err_o (not ack_o) on a miss, regardless of busy_i, with no state change.
REQ-025 SHALL commit writes only in the ack cycle; writes to ID and STATUS are acked and ignored.
REQ-026 SHALL drive dat_o with the register value during the ack cycle of a read, and with 0 in all other cycles.
REQ-027 SHALL increment ACCESS_CNT on every ack, wrapping from 32'hFFFFFFFF to 0; err/rty terminations do not count.
REQ-028 SHALL give clear priority over increment on a write to ACCESS_CNT: the result is 0.
REQ-029 SHALL, if cyc_i is low in any WAIT or RESP cycle, abort to IDLE with no termination, no write and no count.

Reset
REQ-030 SHALL, with rst_i high at a clock edge, enter IDLE and clear ack_o, err_o, rty_o, dat_o, CTRL (ctrl_o=0), SCRATCH and ACCESS_CNT; reset overrides any in-flight access, which is lost.

Configuration
REQ-031 SHALL compile with macro WBSLV_RTY_EN defined as follows: if busy_i is high in the cycle RESP would ack, assert rty_o instead of ack_o, with no write and no count.
REQ-032 SHALL compile without WBSLV_RTY_EN as follows: busy_i high holds the FSM in WAIT (counter at 0) until busy_i is low; rty_o is tied to 0.

Verification
REQ-033 SHALL verify: with WAIT_STATES=1, read adr 0 in cycle N -> ack_o in cycle N+2, dat_o=32'h57425347, then dat_o=0.
REQ-034 SHALL verify: write 32'hDEADBEEF to adr 1, then read adr 1 -> ctrl_o=32'hDEADBEEF after the ack, read returns the same value, ACCESS_CNT=2.
REQ-035 SHALL verify: read adr 21'h000008 with BASE_ADR=0 -> err_o for one cycle, ACCESS_CNT unchanged.
REQ-036 SHALL verify: write adr 3 with ACCESS_CNT=5 -> ack_o, then a read of adr 3 returns 0 in the data and 1 in the next read.
REQ-037 SHALL verify: busy_i high through the response cycle -> with WBSLV_RTY_EN, rty_o and SCRATCH unchanged; without it, ack_o is delayed until the cycle after busy_i falls.
REQ-038 SHALL verify: write to adr 4 with cyc_i dropped during WAIT, or rst_i pulsed during WAIT -> no termination, SCRATCH reg 4 = 0.
